// File: rtl/store_buffer.sv
// store_buffer: aligning circular store FIFO between the MEM stage and dmem.
// Define STORE_BUFFER_LD_HAZARD_EN to add the ld_addr/ld_hazard load-hazard check.
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_funct3,
  output logic                     dmem_valid,
  input  logic                     dmem_ready,
  output logic [31:0]              dmem_addr,
  output logic [31:0]              dmem_wdata,
  output logic [3:0]               dmem_wen,
  output logic                     misalign,
`ifdef STORE_BUFFER_LD_HAZARD_EN
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  // entry layout: {addr[31:2], wdata, wen}
  logic [65:0]   mem_q [DEPTH];
  logic [65:0]   mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          misalign_q, misalign_d;
  logic [1:0]    off;
  logic          sb, sh, sw, ok, acc, push, pop;
  logic [31:0]   wdata;
  logic [3:0]    wen;
  logic [65:0]   head;
  always_comb begin
    off        = st_addr[1:0];
    sb         = st_funct3 == 3'b000;
    sh         = st_funct3 == 3'b001 && !off[0];
    sw         = st_funct3 == 3'b010 && off == 2'b00;
    ok         = sb || sh || sw;
    wdata      = sb ? {4{st_data[7:0]}} : sh ? {2{st_data[15:0]}} : st_data;
    wen        = sb ? 4'b0001 << off : sh ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_ready   = count_q != (AW+1)'(DEPTH);
    dmem_valid = count_q != '0;
    acc        = st_valid && st_ready;
    push       = acc && ok;
    pop        = dmem_valid && dmem_ready;
    misalign_d = acc && !ok;
    mem_d      = mem_q;
    if (push) mem_d[wp_q] = {st_addr[31:2], wdata, wen};
    wp_d       = push ? wp_q + 1'b1 : wp_q;
    rp_d       = pop ? rp_q + 1'b1 : rp_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    head       = dmem_valid ? mem_q[rp_q] : '0;
    dmem_addr  = {head[65:36], 2'b00};
    dmem_wdata = head[35:4];
    dmem_wen   = head[3:0];
    misalign   = misalign_q;
    count      = count_q;
  end
`ifdef STORE_BUFFER_LD_HAZARD_EN
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hazard = ld_hazard | (({1'b0, AW'(i) - rp_q} < count_q) && mem_q[i][3:0] != 4'b0000 &&
                  ((({mem_q[i][65:36], 2'b00} ^ ld_addr) & 32'hFFFF_FFFC) == 32'h0));
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors for store_buffer (DEPTH=2), hazard check when STORE_BUFFER_LD_HAZARD_EN is set.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_funct3 = '0;
  logic        dmem_valid;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wen;
  logic        misalign;
  logic [1:0]  count;
  int          checks = 0;
  int          errors = 0;
`ifdef STORE_BUFFER_LD_HAZARD_EN
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
`endif
  store_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen), .misalign(misalign),
`ifdef STORE_BUFFER_LD_HAZARD_EN
    .ld_addr(ld_addr), .ld_hazard(ld_hazard),
`endif
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    st_funct3 = f;
  endtask
  initial begin
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(dmem_valid), 0);
    chk("rst_ready", 32'(st_ready), 1);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_wen", 32'(dmem_wen), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    rst_n = 1'b1;
    tick();
    dmem_ready = 1'b1;
    store(32'h1003, 32'h0000_00AB, 3'b000);
    tick();
    st_valid = 1'b0;
    chk("sb_count", 32'(count), 1);
    chk("sb_valid", 32'(dmem_valid), 1);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_wen", 32'(dmem_wen), 32'h8);
    tick();
    chk("sb_drained", 32'(count), 0);
    chk("sb_empty_wen", 32'(dmem_wen), 0);
    dmem_ready = 1'b0;
    store(32'h2002, 32'h1234BEEF, 3'b001);
    tick();
    st_valid = 1'b0;
    chk("sh_addr", dmem_addr, 32'h2000);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_wen", 32'(dmem_wen), 32'hC);
    tick();
    chk("sh_hold_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_hold_wen", 32'(dmem_wen), 32'hC);
    dmem_ready = 1'b1;
    tick();
    chk("sh_drained", 32'(count), 0);
    store(32'h3001, 32'hDEADBEEF, 3'b010);
    tick();
    st_valid = 1'b0;
    chk("sw_mis_pulse", 32'(misalign), 1);
    chk("sw_mis_count", 32'(count), 0);
    chk("sw_mis_valid", 32'(dmem_valid), 0);
    tick();
    chk("sw_mis_clear", 32'(misalign), 0);
    store(32'h2001, 32'h1, 3'b001);
    tick();
    chk("sh_odd_mis", 32'(misalign), 1);
    store(32'h4000, 32'h1, 3'b011);
    tick();
    st_valid = 1'b0;
    chk("f3_bad_mis", 32'(misalign), 1);
    chk("f3_bad_count", 32'(count), 0);
    dmem_ready = 1'b0;
    store(32'h10, 32'h11111111, 3'b010);
    tick();
    store(32'h14, 32'h22222222, 3'b010);
    tick();
    chk("full_count", 32'(count), 2);
    chk("full_ready", 32'(st_ready), 0);
    store(32'h18, 32'h33333333, 3'b010);
    tick();
    chk("full_stall", 32'(count), 2);
    chk("head_a_addr", dmem_addr, 32'h10);
    chk("head_a_data", dmem_wdata, 32'h11111111);
    dmem_ready = 1'b1;
    tick();
    chk("nobypass_count", 32'(count), 1);
    chk("head_b_addr", dmem_addr, 32'h14);
    chk("head_b_data", dmem_wdata, 32'h22222222);
    chk("after_pop_ready", 32'(st_ready), 1);
    tick();
    st_valid = 1'b0;
    chk("pushpop_count", 32'(count), 1);
    chk("head_c_addr", dmem_addr, 32'h18);
    chk("head_c_data", dmem_wdata, 32'h33333333);
    tick();
    chk("order_drained", 32'(count), 0);
    dmem_ready = 1'b0;
    store(32'h20, 32'h44444444, 3'b010);
    tick();
    tick();
    st_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_valid", 32'(dmem_valid), 0);
    chk("async_ready", 32'(st_ready), 1);
    chk("async_wen", 32'(dmem_wen), 0);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(dmem_valid), 0);
    tick();
    chk("post_rst_count", 32'(count), 0);
`ifdef STORE_BUFFER_LD_HAZARD_EN
    dmem_ready = 1'b0;
    store(32'h4001, 32'h000000CD, 3'b000);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h4002;
    #1;
    chk("haz_hit", 32'(ld_hazard), 1);
    ld_addr = 32'h5002;
    #1;
    chk("haz_miss", 32'(ld_hazard), 0);
    ld_addr = 32'h4002;
    dmem_ready = 1'b1;
    tick();
    chk("haz_drained", 32'(ld_hazard), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of store entries held (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  meaning the core clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port st_valid  input  1  meaning the MEM stage presents a store.
REQ-005 SHALL have port st_ready  output  1  meaning the buffer accepts a store this cycle.
REQ-006 SHALL have port st_addr  input  32  meaning the byte address of the store.
REQ-007 SHALL have port st_data  input  32  meaning rs2 data, unaligned, with the valid bytes in the LSBs.
REQ-008 SHALL have port st_funct3  input  3  meaning 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port dmem_valid  output  1  meaning the head entry is presented to dmem.
REQ-010 SHALL have port dmem_ready  input  1  meaning dmem takes the head entry this cycle.
REQ-011 SHALL have port dmem_addr  output  32  meaning the word-aligned write address, with [1:0]=00.
REQ-012 SHALL have port dmem_wdata  output  32  meaning the lane-replicated write data.
REQ-013 SHALL have port dmem_wen  output  4  meaning the per-byte write strobe.
REQ-014 SHALL have port misalign  output  1  meaning a one-cycle pulse when a store is rejected.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  meaning the number of occupied entries.

Function
REQ-016 SHALL accept a store on st_valid && st_ready, where st_ready = (count != DEPTH); no bypass when full, even if a pop occurs in the same cycle.
REQ-017 SHALL align at accept, with off = st_addr[1:0]:
- SB: wdata = {4{st_data[7:0]}}, wen = 4'b0001 << off.
- SH: wdata = {2{st_data[15:0]}}, wen = 0011 (off 0) or 1100 (off 2).
- SW: wdata = st_data, wen = 1111.
REQ-018 SHALL treat SH with odd off, SW with off != 0, or any other funct3 as misaligned; such a store is consumed (handshake completes), not enqueued, and misalign is registered high for exactly the next cycle.
REQ-019 SHALL store {st_addr[31:2], 2'b00, wdata, wen} per entry in a circular FIFO, with read and write pointers wrapping modulo DEPTH.
REQ-020 SHALL drive dmem_valid = (count != 0) and present the head entry on dmem_addr, dmem_wdata, and dmem_wen; when the FIFO is empty, all three outputs SHALL be 0.
REQ-021 SHALL pop the head on dmem_valid && dmem_ready.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-023 SHALL present an accepted store on the dmem outputs no earlier than the cycle after the handshake (latency 1 when empty).
REQ-024 SHALL hold head outputs stable while dmem_valid && !dmem_ready.
REQ-025 SHALL drain entries strictly in acceptance order.

Reset
REQ-026 SHALL, on rst_n low and regardless of clk, clear:
- pointers, count, and misalign to 0;
- dmem_valid, dmem_wen, dmem_addr, and dmem_wdata to 0;
- st_ready to 1 (and ld_hazard to 0 when present).
REQ-027 SHALL discard all pending entries when reset is asserted mid-operation, with no dmem write issued after assertion.

Configuration
REQ-028 SHALL compile hazard detection in only when macro STORE_BUFFER_LD_HAZARD_EN is defined.
- With the macro, the block adds ports ld_addr (input, 32) and ld_hazard (output, 1).
- ld_hazard is combinationally high when any occupied entry has addr[31:2] == ld_addr[31:2] and wen != 0.
- Without the macro, these ports SHALL NOT exist and no comparators SHALL be built.

Verification
REQ-029 SHALL cover SB to 0x1003 with data 0xAB and dmem_ready=1 -> next cycle dmem_addr=0x1000, dmem_wdata=0xABABABAB, dmem_wen=1000; count returns to 0 the cycle after.
REQ-030 SHALL cover SH to 0x2002 with data 0x1234BEEF -> dmem_wdata=0xBEEFBEEF, dmem_wen=1100.
REQ-031 SHALL cover SW to 0x3001 -> misalign=1 for one cycle, count stays 0, and dmem_valid stays 0.
REQ-032 SHALL cover DEPTH=2 with dmem_ready=0 and three back-to-back SWs -> st_ready=0 after two accepts, count=2; raising dmem_ready drains the entries in order, and the third store is accepted only after a pop.
REQ-033 SHALL cover rst_n asserted low mid-clock with count=2 -> immediately count=0, dmem_valid=0, st_ready=1.
REQ-034 SHALL cover, with STORE_BUFFER_LD_HAZARD_EN defined, a pending SB to 0x4001 and ld_addr=0x4002 -> ld_hazard=1; after the drain, ld_hazard=0.
